// File: rtl/heap_cmd_arbiter_if.sv
// heap_cmd_arbiter_if: command/response channel between the button front-end and the heap engine.
//   cmd_valid/cmd_ready : valid/ready handshake for one heap command
//   cmd_op              : 0 PUSH, 1 POP, 2 TOP, 3 SIZE
//   cmd_data            : push operand (0 for other ops)
//   rsp_valid           : one-cycle response strobe from the heap
//   rsp_data            : popped/top value or size
//   rsp_err             : heap full on PUSH, empty on POP/TOP
// Modports: master = arbiter side, slave = heap side.
interface heap_cmd_arbiter_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic              cmd_valid;
   logic [1:0]        cmd_op;
   logic [DATA_W-1:0] cmd_data;
   logic              cmd_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/heap_cmd_arbiter.sv
// heap_cmd_arbiter: turns the four operator buttons into single heap commands.
// Buttons are synchronised and edge-detected into pending requests; one request is granted at a
// time, issued over the valid/ready command channel, and the heap response is latched onto
// disp/leds.
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   btns_i      raw buttons: [0] PUSH, [1] POP, [2] TOP, [3] SIZE
//   switches_i  push operand, captured on a PUSH edge
//   heap_io     command/response channel (master modport); its DATA_W must match this module's
//   disp_o      last successful POP/TOP/SIZE response value
//   leds_o      [3:0] one-hot last op, [4] rsp_err, [5] timeout, [6] busy, [7] sticky overrun
//   busy_o      FSM not idle
// Build option: define HEAP_ARB_RR_EN for round-robin arbitration (default: fixed priority,
// lowest index first).
module heap_cmd_arbiter #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [3:0]         btns_i,
   input  logic [DATA_W-1:0]  switches_i,
   heap_cmd_arbiter_if.master heap_io,
   output logic [DATA_W-1:0]  disp_o,
   output logic [7:0]         leds_o,
   output logic               busy_o
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2
   } state_e;

   state_e                      state_q, state_d;
   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic [3:0]                  btn_prev_q;
   logic [3:0]                  rise;
   logic [3:0]                  pending_q, pending_d;
   logic [3:0]                  clr;
   logic                        overrun_q, overrun_d;
   logic [DATA_W-1:0]           push_q, push_d;
   logic                        cmd_valid_q, cmd_valid_d;
   logic [1:0]                  cmd_op_q, cmd_op_d;
   logic [DATA_W-1:0]           cmd_data_q, cmd_data_d;
   logic [7:0]                  timer_q, timer_d;
   logic [5:0]                  status_q, status_d;
   logic [DATA_W-1:0]           disp_q, disp_d;
   logic [1:0]                  grant;
   logic                        handshake;

   // Synchroniser chain plus one delayed copy for rising-edge detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q     <= '0;
         btn_prev_q <= '0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], btns_i};
         btn_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~btn_prev_q;

   // Set wins over a same-cycle clear; a repeated edge only flags overrun.
   always_comb begin
      clr = '0;
      if (handshake) begin
         clr[cmd_op_q] = 1'b1;
      end
      pending_d = (pending_q & ~clr) | rise;
      overrun_d = overrun_q | (|(rise & pending_q));
      push_d    = rise[0] ? switches_i : push_q;
   end

`ifdef HEAP_ARB_RR_EN
   // Pointer holds last_grant+1; the search starts there and wraps 3 -> 0.
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] idx;

   always_comb begin
      grant = '0;
      idx   = '0;
      // Walk downwards so the candidate closest to the pointer is assigned last and wins.
      for (int k = 3; k >= 0; k--) begin
         idx = ptr_q + 2'(k);
         if (pending_q[idx]) begin
            grant = idx;
         end
      end
   end

   assign ptr_d = handshake ? (cmd_op_q + 2'd1) : ptr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      grant = '0;
      // Walk downwards so the lowest set index is assigned last and wins.
      for (int k = 3; k >= 0; k--) begin
         if (pending_q[k]) begin
            grant = 2'(k);
         end
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      cmd_valid_d = cmd_valid_q;
      cmd_op_d    = cmd_op_q;
      cmd_data_d  = cmd_data_q;
      timer_d     = timer_q;
      status_d    = status_q;
      disp_d      = disp_q;
      handshake   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|pending_q) begin
               cmd_op_d    = grant;
               cmd_data_d  = (grant == 2'd0) ? push_q : '0;
               cmd_valid_d = 1'b1;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            if (heap_io.cmd_ready) begin
               handshake   = 1'b1;
               cmd_valid_d = 1'b0;
               timer_d     = '0;
               state_d     = StWait;
            end
         end
         StWait: begin
            timer_d = timer_q + 8'd1;
            if (heap_io.rsp_valid) begin
               status_d = {1'b0, heap_io.rsp_err, 4'b0001 << cmd_op_q};
               if ((cmd_op_q != 2'd0) && !heap_io.rsp_err) begin
                  disp_d = heap_io.rsp_data;
               end
               state_d = StIdle;
            end else if (timer_q == 8'(TIMEOUT - 1)) begin
               // Abort: last op/err indication stays, only the timeout flag is raised.
               status_d[5] = 1'b1;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         pending_q   <= '0;
         overrun_q   <= 1'b0;
         push_q      <= '0;
         cmd_valid_q <= 1'b0;
         cmd_op_q    <= '0;
         cmd_data_q  <= '0;
         timer_q     <= '0;
         status_q    <= '0;
         disp_q      <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         push_q      <= push_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_op_q    <= cmd_op_d;
         cmd_data_q  <= cmd_data_d;
         timer_q     <= timer_d;
         status_q    <= status_d;
         disp_q      <= disp_d;
      end
   end

   assign heap_io.cmd_valid = cmd_valid_q;
   assign heap_io.cmd_op    = cmd_op_q;
   assign heap_io.cmd_data  = cmd_data_q;
   assign busy_o            = (state_q != StIdle);
   assign disp_o            = disp_q;
   assign leds_o            = {overrun_q, busy_o, status_q};

endmodule
